// File: rtl/rom_port_arbiter.sv
// Two-master arbiter for a shared synchronous-read ROM: same-cycle grant,
// pipelined issue, and read data routed back to whichever master owns the access.
module rom_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ROM_LAT    = 1,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              rom_en_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i
);

    logic               last_gnt_q, last_gnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ROM_LAT-1:0] vld_q, vld_d;
    logic [ROM_LAT-1:0] id_q, id_d;
    logic               gnt0, gnt1;
    logic               rsp_vld;

    // last_gnt_q = 1 means M1 was granted last, so M0 wins the next tie
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (m0_req_i && m1_req_i) begin
                if ((FIXED_PRIO != 0) || last_gnt_q) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = m0_req_i;
                gnt1 = m1_req_i;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        addr_d     = addr_q;
        if (gnt0) begin
            last_gnt_d = 1'b0;
            addr_d     = m0_addr_i;
        end else if (gnt1) begin
            last_gnt_d = 1'b1;
            addr_d     = m1_addr_i;
        end
    end

    // Owner pipeline: entry reaches the last stage exactly when the ROM data is valid
    always_comb begin
        vld_d    = vld_q;
        id_d     = id_q;
        vld_d[0] = gnt0 | gnt1;
        id_d[0]  = gnt1;
        for (int unsigned i = 1; i < ROM_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
            addr_q     <= '0;
            vld_q      <= '0;
            id_q       <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            addr_q     <= addr_d;
            vld_q      <= vld_d;
            id_q       <= id_d;
        end
    end

    assign rsp_vld     = vld_q[ROM_LAT-1] & ~rst;
    assign m0_gnt_o    = gnt0;
    assign m1_gnt_o    = gnt1;
    assign rom_en_o    = gnt0 | gnt1;
    assign rom_addr_o  = rst ? '0 : addr_d;
    assign m0_rvalid_o = rsp_vld & ~id_q[ROM_LAT-1];
    assign m1_rvalid_o = rsp_vld & id_q[ROM_LAT-1];
    assign m0_rdata_o  = m0_rvalid_o ? rom_data_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? rom_data_i : '0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: three configurations (LAT1/RR, LAT3/fixed, LAT2/RR),
// a vector table, directed corner sequences and random traffic against a grant-log model.
module tb_rom_port_arbiter;

    localparam int NI = 3;
    localparam int NC = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req  [NI];
    logic [31:0] m0_addr [NI];
    logic        m1_req  [NI];
    logic [31:0] m1_addr [NI];
    logic        g0_w    [NI];
    logic        g1_w    [NI];
    logic        rv0_w   [NI];
    logic        rv1_w   [NI];
    logic [31:0] rd0_w   [NI];
    logic [31:0] rd1_w   [NI];
    logic        en_w    [NI];
    logic [31:0] ra_w    [NI];
    logic [31:0] rdat_w  [NI];

    always #5 clk = ~clk;

    rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ROM_LAT(1), .FIXED_PRIO(0)) u0 (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req[0]), .m0_addr_i(m0_addr[0]), .m0_gnt_o(g0_w[0]),
        .m0_rvalid_o(rv0_w[0]), .m0_rdata_o(rd0_w[0]),
        .m1_req_i(m1_req[0]), .m1_addr_i(m1_addr[0]), .m1_gnt_o(g1_w[0]),
        .m1_rvalid_o(rv1_w[0]), .m1_rdata_o(rd1_w[0]),
        .rom_en_o(en_w[0]), .rom_addr_o(ra_w[0]), .rom_data_i(rdat_w[0]));

    rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ROM_LAT(3), .FIXED_PRIO(1)) u1 (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req[1]), .m0_addr_i(m0_addr[1]), .m0_gnt_o(g0_w[1]),
        .m0_rvalid_o(rv0_w[1]), .m0_rdata_o(rd0_w[1]),
        .m1_req_i(m1_req[1]), .m1_addr_i(m1_addr[1]), .m1_gnt_o(g1_w[1]),
        .m1_rvalid_o(rv1_w[1]), .m1_rdata_o(rd1_w[1]),
        .rom_en_o(en_w[1]), .rom_addr_o(ra_w[1]), .rom_data_i(rdat_w[1]));

    rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ROM_LAT(2), .FIXED_PRIO(0)) u2 (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req[2]), .m0_addr_i(m0_addr[2]), .m0_gnt_o(g0_w[2]),
        .m0_rvalid_o(rv0_w[2]), .m0_rdata_o(rd0_w[2]),
        .m1_req_i(m1_req[2]), .m1_addr_i(m1_addr[2]), .m1_gnt_o(g1_w[2]),
        .m1_rvalid_o(rv1_w[2]), .m1_rdata_o(rd1_w[2]),
        .rom_en_o(en_w[2]), .rom_addr_o(ra_w[2]), .rom_data_i(rdat_w[2]));

    // ROM models: word = address + 3, garbage when no read was issued LAT cycles ago
    logic        re [NI][4];
    logic [31:0] ra [NI][4];
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            for (int i = 3; i > 0; i--) begin
                re[k][i] <= re[k][i-1];
                ra[k][i] <= ra[k][i-1];
            end
            re[k][0] <= en_w[k];
            ra[k][0] <= ra_w[k];
        end
    end
    assign rdat_w[0] = re[0][0] ? ra[0][0] + 32'd3 : 32'hDEAD_BEEF;
    assign rdat_w[1] = re[1][2] ? ra[1][2] + 32'd3 : 32'hDEAD_BEEF;
    assign rdat_w[2] = re[2][1] ? ra[2][1] + 32'd3 : 32'hDEAD_BEEF;

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 2;
    endfunction
    function automatic bit fp_of(int k);
        return k == 1;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[u%0d] cyc %0d got %h exp %h", name, k, cyc, act, exp);
        end
    endtask

    // Reference model: a log of every grant per cycle; a response is due LAT cycles later
    // unless a reset occurred after the grant.
    int          cyc      = 0;
    int          last_rst = -1;
    logic        lastg [NI];
    logic [31:0] hold  [NI];
    logic        eg0   [NI];
    logic        eg1   [NI];
    logic        gv    [NI][NC];
    logic        gid   [NI][NC];
    logic [31:0] gad   [NI][NC];

    task automatic eval();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            logic e0, e1, ev0, ev1;
            logic [31:0] ea, ed0, ed1;
            int c0;
            e0 = 0; e1 = 0; ev0 = 0; ev1 = 0; ea = 0; ed0 = 0; ed1 = 0;
            if (rst) begin
                lastg[k] = 1'b1;
                hold[k]  = 0;
            end else begin
                if (m0_req[k] && m1_req[k]) begin
                    if (fp_of(k) || lastg[k]) e0 = 1; else e1 = 1;
                end else begin
                    e0 = m0_req[k];
                    e1 = m1_req[k];
                end
                ea = e0 ? m0_addr[k] : e1 ? m1_addr[k] : hold[k];
                c0 = cyc - lat_of(k);
                if (c0 > last_rst && gv[k][c0]) begin
                    if (gid[k][c0]) begin ev1 = 1; ed1 = gad[k][c0] + 32'd3; end
                    else            begin ev0 = 1; ed0 = gad[k][c0] + 32'd3; end
                end
            end
            chk("m0_gnt",    k, 32'(g0_w[k]),  32'(e0));
            chk("m1_gnt",    k, 32'(g1_w[k]),  32'(e1));
            chk("rom_en",    k, 32'(en_w[k]),  32'(e0 | e1));
            chk("rom_addr",  k, ra_w[k],       ea);
            chk("m0_rvalid", k, 32'(rv0_w[k]), 32'(ev0));
            chk("m0_rdata",  k, rd0_w[k],      ed0);
            chk("m1_rvalid", k, 32'(rv1_w[k]), 32'(ev1));
            chk("m1_rdata",  k, rd1_w[k],      ed1);
            gv[k][cyc]  = e0 | e1;
            gid[k][cyc] = e1;
            gad[k][cyc] = ea;
            if (e0 | e1) begin
                lastg[k] = e1;
                hold[k]  = ea;
            end
            eg0[k] = e0;
            eg1[k] = e1;
        end
        if (rst) last_rst = cyc;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_all();
        for (int k = 0; k < NI; k++) begin
            m0_req[k] = 0; m1_req[k] = 0;
        end
    endtask

    typedef struct {
        logic        rst, r0;
        logic [31:0] a0;
        logic        r1;
        logic [31:0] a1;
        logic        g0, g1, en;
        logic [31:0] addr;
        logic        rv0;
        logic [31:0] rd0;
        logic        rv1;
        logic [31:0] rd1;
    } vec_t;

    function automatic vec_t mk(logic rs, logic r0, logic [31:0] a0, logic r1, logic [31:0] a1,
                                logic g0, logic g1, logic [31:0] addr,
                                logic rv0, logic [31:0] rd0, logic rv1, logic [31:0] rd1);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
        v.g0 = g0; v.g1 = g1; v.en = g0 | g1; v.addr = addr;
        v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.rd1 = rd1;
        return v;
    endfunction

    vec_t tbl [24];

    initial begin
        for (int k = 0; k < NI; k++) begin
            m0_req[k] = 0; m0_addr[k] = 0; m1_req[k] = 0; m1_addr[k] = 0;
            lastg[k] = 1; hold[k] = 0; eg0[k] = 0; eg1[k] = 0;
            for (int c = 0; c < NC; c++) begin
                gv[k][c] = 0; gid[k][c] = 0; gad[k][c] = 0;
            end
        end

        // Vector table for u0 (ROM_LAT=1, round-robin)
        tbl[0]  = mk(1, 0, 0,     0, 0,     0, 0, 0,     0, 0,     0, 0);
        tbl[1]  = mk(0, 1, 'h10,  0, 0,     1, 0, 'h10,  0, 0,     0, 0);
        tbl[2]  = mk(0, 0, 0,     0, 0,     0, 0, 'h10,  1, 'h13,  0, 0);
        tbl[3]  = mk(1, 0, 0,     0, 0,     0, 0, 0,     0, 0,     0, 0);
        tbl[4]  = mk(0, 1, 'h100, 1, 'h200, 1, 0, 'h100, 0, 0,     0, 0);
        tbl[5]  = mk(0, 1, 'h104, 1, 'h200, 0, 1, 'h200, 1, 'h103, 0, 0);
        tbl[6]  = mk(0, 1, 'h104, 1, 'h204, 1, 0, 'h104, 0, 0,     1, 'h203);
        tbl[7]  = mk(0, 1, 'h108, 1, 'h204, 0, 1, 'h204, 1, 'h107, 0, 0);
        tbl[8]  = mk(0, 1, 'h108, 1, 'h208, 1, 0, 'h108, 0, 0,     1, 'h207);
        tbl[9]  = mk(0, 1, 'h10C, 1, 'h208, 0, 1, 'h208, 1, 'h10B, 0, 0);
        tbl[10] = mk(0, 1, 'h10C, 1, 'h20C, 1, 0, 'h10C, 0, 0,     1, 'h20B);
        tbl[11] = mk(0, 1, 'h110, 1, 'h20C, 0, 1, 'h20C, 1, 'h10F, 0, 0);
        tbl[12] = mk(0, 1, 'h110, 0, 0,     1, 0, 'h110, 0, 0,     1, 'h20F);
        tbl[13] = mk(0, 0, 0,     0, 0,     0, 0, 'h110, 1, 'h113, 0, 0);
        for (int i = 14; i < 24; i++)
            tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 'h110, 0, 0, 0, 0);

        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            idle_all();
            rst        = tbl[i].rst;
            m0_req[0]  = tbl[i].r0;
            m0_addr[0] = tbl[i].a0;
            m1_req[0]  = tbl[i].r1;
            m1_addr[0] = tbl[i].a1;
            eval();
            chk("tbl_g0",   0, 32'(g0_w[0]),  32'(tbl[i].g0));
            chk("tbl_g1",   0, 32'(g1_w[0]),  32'(tbl[i].g1));
            chk("tbl_en",   0, 32'(en_w[0]),  32'(tbl[i].en));
            chk("tbl_addr", 0, ra_w[0],       tbl[i].addr);
            chk("tbl_rv0",  0, 32'(rv0_w[0]), 32'(tbl[i].rv0));
            chk("tbl_rd0",  0, rd0_w[0],      tbl[i].rd0);
            chk("tbl_rv1",  0, 32'(rv1_w[0]), 32'(tbl[i].rv1));
            chk("tbl_rd1",  0, rd1_w[0],      tbl[i].rd1);
            adv();
        end

        // Fixed priority on u1: M1 starved while M0 keeps requesting
        idle_all();
        rst = 1; eval(); adv(); rst = 0;
        for (int i = 0; i < 4; i++) begin
            m0_req[1] = 1; m0_addr[1] = 32'h1000 + 32'(4 * i);
            m1_req[1] = 1; m1_addr[1] = 32'h2000;
            eval();
            chk("fp_m1_wait", 1, 32'(g1_w[1]), 0);
            chk("fp_m0_win",  1, 32'(g0_w[1]), 1);
            adv();
        end
        m0_req[1] = 0;
        eval();
        chk("fp_m1_gnt", 1, 32'(g1_w[1]), 1);
        adv();
        m1_req[1] = 0;
        for (int i = 0; i < 5; i++) begin eval(); adv(); end

        // Back-to-back M0 reads on u1 with ROM_LAT=3
        for (int i = 0; i < 3; i++) begin
            m0_req[1] = 1; m0_addr[1] = 32'(4 * i);
            eval();
            chk("b2b_en", 1, 32'(en_w[1]), 1);
            adv();
        end
        m0_req[1] = 0;
        for (int j = 0; j < 4; j++) begin
            eval();
            chk("b2b_rv0", 1, 32'(rv0_w[1]), (j < 3) ? 32'd1 : 32'd0);
            chk("b2b_rd0", 1, rd0_w[1], (j < 3) ? 32'(4 * j + 3) : 32'd0);
            adv();
        end

        // Reset right after an M1 grant on u2 (ROM_LAT=2) discards the access
        m1_req[2] = 1; m1_addr[2] = 32'h3000;
        eval();
        chk("rst_m1_gnt", 2, 32'(g1_w[2]), 1);
        adv();
        m1_req[2] = 0; rst = 1;
        eval();
        chk("rst_rv1", 2, 32'(rv1_w[2]), 0);
        chk("rst_en",  2, 32'(en_w[2]),  0);
        adv();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("post_rst_rv1", 2, 32'(rv1_w[2]), 0);
            adv();
        end

        // Random traffic: masters hold req/addr until the model says they were granted
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            for (int k = 0; k < NI; k++) begin
                if (!m0_req[k] || eg0[k]) begin
                    m0_req[k]  = ($urandom_range(0, 9) < 6);
                    m0_addr[k] = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                end
                if (!m1_req[k] || eg1[k]) begin
                    m1_req[k]  = ($urandom_range(0, 9) < 6);
                    m1_addr[k] = ($urandom_range(0, 3) == 0) ? m0_addr[k]
                                 : {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                end
            end
            eval();
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
